// File: rtl/tsp16_pkg.sv
// Shared definitions for the TSP16 pipeline: opcodes, instruction field
// positions and the MEM-stage state type.
package tsp16_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned RN_LSB = 3;
  localparam int unsigned RD_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_LDR = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_STR = 4'b0101;

  typedef enum logic {
    IDLE,
    BUSY
  } mem_state_t;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LDR) || (opc == OPC_STR);
  endfunction

endpackage

// File: rtl/mem_fwd_mux.sv
// Selects the MEM stage's own retired result over a stale regfile value when
// the retired instruction wrote the register being read.
module mem_fwd_mux #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
) (
  input  logic              fwd_valid,
  input  logic [REG_W-1:0]  fwd_reg,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic [REG_W-1:0]  sel_reg,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data
);

  // Bypass select: forwarded result wins on a register-number match
  always_comb begin
    data = rf_data;
    if (fwd_valid && (fwd_reg == sel_reg)) data = fwd_data;
  end

endmodule

// File: rtl/pipeline_mem_stage.sv
// MEM stage of the TSP16 pipeline: executes LDR/STR over a req/ack memory
// port, passes other instructions straight through, and stalls EXECUTE while
// a transfer is outstanding. An optional timeout retires a hung access.
module pipeline_mem_stage
  import tsp16_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic               ex_is_dependent,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [INSTR_W-1:0] ex_instr,
  output logic               ex_ready,
  output logic [REG_W-1:0]   rf_rn_num,
  output logic [REG_W-1:0]   rf_rd_num,
  input  logic [DATA_W-1:0]  rf_rn,
  input  logic [DATA_W-1:0]  rf_rd,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_done,
  output logic               mem_is_dependent,
  output logic [DATA_W-1:0]  mem_result,
  output logic [INSTR_W-1:0] mem_instr,
  output logic               mem_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  mem_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               req_n, we_n, done_n, dep_n, err_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [DATA_W-1:0]  wdata_n, result_n;
  logic [INSTR_W-1:0] instr_n;
  logic [DATA_W-1:0]  addr_fwd, wdata_fwd;
  logic [OPC_W-1:0]   opc;
  logic               fwd_valid;
  logic               timeout_hit;

  assign opc         = ex_instr[INSTR_W-1 -: OPC_W];
  assign rf_rn_num   = ex_instr[RN_LSB +: REG_W];
  assign rf_rd_num   = ex_instr[RD_LSB +: REG_W];
  assign ex_ready    = (state == IDLE);
  assign fwd_valid   = mem_done && mem_is_dependent;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  mem_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_addr_fwd (
    .fwd_valid (fwd_valid),
    .fwd_reg   (mem_instr[RD_LSB +: REG_W]),
    .fwd_data  (mem_result),
    .sel_reg   (rf_rn_num),
    .rf_data   (rf_rn),
    .data      (addr_fwd)
  );

  mem_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_wdata_fwd (
    .fwd_valid (fwd_valid),
    .fwd_reg   (mem_instr[RD_LSB +: REG_W]),
    .fwd_data  (mem_result),
    .sel_reg   (rf_rd_num),
    .rf_data   (rf_rd),
    .data      (wdata_fwd)
  );

  // Next-state and next-output logic; instr/result/dependent are latched
  // straight into the mem_* registers on entry to BUSY since mem_done=0 hides them
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    req_n    = mem_req;
    we_n     = mem_we;
    addr_n   = mem_addr;
    wdata_n  = mem_wdata;
    done_n   = 1'b0;
    dep_n    = mem_is_dependent;
    result_n = mem_result;
    instr_n  = mem_instr;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (!ex_valid) begin
          dep_n = 1'b0;
        end else if (is_mem_op(opc)) begin
          state_n  = BUSY;
          cnt_n    = '0;
          req_n    = 1'b1;
          we_n     = (opc == OPC_STR);
          addr_n   = addr_fwd[ADDR_W-1:0];
          wdata_n  = wdata_fwd;
          result_n = ex_result;
          instr_n  = ex_instr;
          dep_n    = ex_is_dependent;
        end else begin
          done_n   = 1'b1;
          result_n = ex_result;
          instr_n  = ex_instr;
          dep_n    = ex_is_dependent;
        end
      end
      BUSY: begin
        cnt_n = cnt + CNT_W'(1);
        if (mem_ack) begin
          state_n = IDLE;
          req_n   = 1'b0;
          done_n  = 1'b1;
          if (!mem_we) result_n = mem_rdata;
        end else if (timeout_hit) begin
          state_n  = IDLE;
          req_n    = 1'b0;
          done_n   = 1'b1;
          err_n    = 1'b1;
          result_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_done         <= 1'b0;
      mem_is_dependent <= 1'b0;
      mem_result       <= '0;
      mem_instr        <= '0;
      mem_err          <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      mem_req          <= req_n;
      mem_we           <= we_n;
      mem_addr         <= addr_n;
      mem_wdata        <= wdata_n;
      mem_done         <= done_n;
      mem_is_dependent <= dep_n;
      mem_result       <= result_n;
      mem_instr        <= instr_n;
      mem_err          <= err_n;
    end
  end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Self-checking bench for pipeline_mem_stage with a transaction-level model:
// each instruction's retirement (cycle, result, error) is predicted from the
// ack delay and the forwarding rule, then compared against the DUT.
module tb_pipeline_mem_stage;

  localparam int unsigned TO = 4;
  localparam logic [3:0] LDR = 4'b0100;
  localparam logic [3:0] STR = 4'b0101;
  localparam logic [3:0] ADD = 4'b0001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_is_dependent = 1'b0;
  logic [15:0] ex_result = '0;
  logic [15:0] ex_instr = '0;
  logic        ex_ready;
  logic [2:0]  rf_rn_num, rf_rd_num;
  logic [15:0] rf_rn, rf_rd;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_done, mem_is_dependent, mem_err;
  logic [15:0] mem_result, mem_instr;

  int checks = 0;
  int errors = 0;

  // Bench-owned register file (never written back, so it can hold stale values)
  logic [15:0] regs [8];

  // Model of the last retired instruction, as seen by the forwarding rule
  logic        m_valid = 1'b0;
  logic        m_dep   = 1'b0;
  logic [2:0]  m_rd    = '0;
  logic [15:0] m_res   = '0;

  pipeline_mem_stage #(
    .DATA_W (16), .ADDR_W (16), .INSTR_W (16), .REG_W (3), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset (reset),
    .ex_valid (ex_valid), .ex_is_dependent (ex_is_dependent),
    .ex_result (ex_result), .ex_instr (ex_instr), .ex_ready (ex_ready),
    .rf_rn_num (rf_rn_num), .rf_rd_num (rf_rd_num), .rf_rn (rf_rn), .rf_rd (rf_rd),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_ack (mem_ack), .mem_rdata (mem_rdata),
    .mem_done (mem_done), .mem_is_dependent (mem_is_dependent),
    .mem_result (mem_result), .mem_instr (mem_instr), .mem_err (mem_err)
  );

  always #5 clk = ~clk;

  // Register file read ports
  always_comb begin
    rf_rn = regs[rf_rn_num];
    rf_rd = regs[rf_rd_num];
  end

  function automatic logic [15:0] fwd(input logic [2:0] r);
    return (m_valid && m_dep && (m_rd == r)) ? m_res : regs[r];
  endfunction

  // Issue one instruction and follow it to retirement. ack_dly is the BUSY
  // cycle (1-based) in which the RAM starts acking; beyond TO it never does.
  task automatic issue(input logic [3:0] opc, input logic [2:0] rn, input logic [2:0] rd,
                       input logic dep, input logic [15:0] res,
                       input int unsigned ack_dly, input logic [15:0] rdata);
    logic [15:0] instr, exp_addr, exp_wdata, exp_res;
    logic [5:0]  mid;
    logic        exp_err, is_mem, exp_we;
    int unsigned ret_cyc;
    mid       = 6'($urandom);
    instr     = {opc, mid, rn, rd};
    is_mem    = (opc == LDR) || (opc == STR);
    exp_we    = (opc == STR);
    exp_addr  = fwd(rn);
    exp_wdata = fwd(rd);
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++; $display("FAIL accept_ready: ex_ready=%b expected 1", ex_ready);
    end
    ex_valid = 1'b1; ex_instr = instr; ex_result = res; ex_is_dependent = dep;
    #1;
    checks++;
    if ({rf_rn_num, rf_rd_num} !== {rn, rd}) begin
      errors++; $display("FAIL rf_nums: rn=%0d rd=%0d expected %0d %0d", rf_rn_num, rf_rd_num, rn, rd);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (!is_mem) begin
      checks++;
      if ({mem_done, mem_req, mem_err, mem_is_dependent, mem_result, mem_instr} !==
          {1'b1, 1'b0, 1'b0, dep, res, instr}) begin
        errors++;
        $display("FAIL passthrough: done=%b req=%b err=%b dep=%b res=%h instr=%h expected 1 0 0 %b %h %h",
                 mem_done, mem_req, mem_err, mem_is_dependent, mem_result, mem_instr, dep, res, instr);
      end
      m_valid = 1'b1; m_dep = dep; m_rd = rd; m_res = res;
      return;
    end
    exp_err = (ack_dly > TO);
    ret_cyc = exp_err ? TO : ack_dly;
    exp_res = exp_err ? 16'h0000 : ((opc == LDR) ? rdata : res);
    checks++;
    if ({mem_req, mem_we, mem_done, ex_ready, mem_addr, mem_wdata} !==
        {1'b1, exp_we, 1'b0, 1'b0, exp_addr, exp_wdata}) begin
      errors++;
      $display("FAIL mem_request: req=%b we=%b done=%b rdy=%b addr=%h wdata=%h expected 1 %b 0 0 %h %h",
               mem_req, mem_we, mem_done, ex_ready, mem_addr, mem_wdata, exp_we, exp_addr, exp_wdata);
    end
    for (int unsigned k = 1; k <= ret_cyc; k++) begin
      mem_ack   = (k >= ack_dly);
      mem_rdata = mem_ack ? rdata : 16'($urandom);
      if (k > 1) begin
        checks++;
        if ({mem_req, ex_ready, mem_done, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b0, exp_addr, exp_wdata}) begin
          errors++;
          $display("FAIL busy_hold: cyc=%0d req=%b rdy=%b done=%b addr=%h wdata=%h expected 1 0 0 %h %h",
                   k, mem_req, ex_ready, mem_done, mem_addr, mem_wdata, exp_addr, exp_wdata);
        end
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    checks++;
    if ({mem_done, mem_err, mem_req, ex_ready, mem_is_dependent, mem_result, mem_instr} !==
        {1'b1, exp_err, 1'b0, 1'b1, dep, exp_res, instr}) begin
      errors++;
      $display("FAIL mem_retire: done=%b err=%b req=%b rdy=%b dep=%b res=%h instr=%h expected 1 %b 0 1 %b %h %h",
               mem_done, mem_err, mem_req, ex_ready, mem_is_dependent, mem_result, mem_instr,
               exp_err, dep, exp_res, instr);
    end
    m_valid = 1'b1; m_dep = dep; m_rd = rd; m_res = exp_res;
  endtask

  task automatic bubble();
    ex_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_done, mem_is_dependent, mem_req, mem_err} !== 4'b0000) begin
      errors++;
      $display("FAIL bubble: done=%b dep=%b req=%b err=%b expected 0 0 0 0",
               mem_done, mem_is_dependent, mem_req, mem_err);
    end
    m_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_valid = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_we, mem_done, mem_is_dependent, mem_err, ex_ready,
         mem_addr, mem_wdata, mem_result, mem_instr} !== {6'b000001, 64'h0}) begin
      errors++;
      $display("FAIL reset_state: req=%b we=%b done=%b dep=%b err=%b rdy=%b addr=%h wdata=%h res=%h instr=%h",
               mem_req, mem_we, mem_done, mem_is_dependent, mem_err, ex_ready,
               mem_addr, mem_wdata, mem_result, mem_instr);
    end
    reset = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_passthrough();
    issue(ADD, 3'd1, 3'd2, 1'b1, 16'h1234, 1, 16'h0);
    bubble();
  endtask

  task automatic test_load();
    regs[3] = 16'h0040;
    issue(LDR, 3'd3, 3'd5, 1'b1, 16'h5555, 4, 16'hBEEF);
    bubble();
  endtask

  task automatic test_forwarding();
    regs[2] = 16'h0000;
    regs[1] = 16'h7777;
    issue(ADD, 3'd0, 3'd2, 1'b1, 16'h0080, 1, 16'h0);
    issue(STR, 3'd2, 3'd1, 1'b0, 16'h0101, 2, 16'h0);
    issue(ADD, 3'd0, 3'd1, 1'b1, 16'hA5A5, 1, 16'h0);
    issue(STR, 3'd2, 3'd1, 1'b0, 16'h0202, 1, 16'h0);
    issue(ADD, 3'd0, 3'd4, 1'b0, 16'hCCCC, 1, 16'h0);
    issue(LDR, 3'd4, 3'd4, 1'b1, 16'h0303, 3, 16'h4242);
    bubble();
  endtask

  task automatic test_timeout();
    issue(LDR, 3'd6, 3'd7, 1'b1, 16'h9999, 1000, 16'h0);
    issue(ADD, 3'd7, 3'd0, 1'b0, 16'h0001, 1, 16'h0);
  endtask

  task automatic test_ack_timeout_race();
    issue(LDR, 3'd5, 3'd6, 1'b1, 16'h0000, TO, 16'hD00D);
    bubble();
  endtask

  task automatic test_reset_busy();
    regs[0] = 16'h0123;
    ex_valid = 1'b1; ex_instr = {LDR, 6'h0, 3'd0, 3'd3}; ex_is_dependent = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rb_req_up: req=%b expected 1", mem_req);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1111;
    checks++;
    if ({mem_req, mem_done, ex_ready, mem_result} !== {3'b001, 16'h0000}) begin
      errors++;
      $display("FAIL rb_reset: req=%b done=%b rdy=%b res=%h expected 0 0 1 0000",
               mem_req, mem_done, ex_ready, mem_result);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, mem_done, mem_err, ex_ready, mem_result} !== {4'b0001, 16'h0000}) begin
      errors++;
      $display("FAIL rb_stray_ack: req=%b done=%b err=%b rdy=%b res=%h expected 0 0 0 1 0000",
               mem_req, mem_done, mem_err, ex_ready, mem_result);
    end
    m_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] opc;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = 16'($urandom);
      if ($urandom_range(0, 5) == 0) bubble();
      case ($urandom_range(0, 2))
        0: begin
          opc = 4'($urandom_range(0, 15));
          if (opc == LDR || opc == STR) opc = ADD;
        end
        1: opc = LDR;
        default: opc = STR;
      endcase
      issue(opc, 3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom),
            $urandom_range(1, TO + 2), 16'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h0011);
    test_reset();
    test_passthrough();
    test_load();
    test_forwarding();
    test_timeout();
    test_ack_timeout_race();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
